ex1_window_avg: RTL and testbench

Downstream consumer of the ex1 datapath's 8-bit `out` stream.
- Accepts one sample per valid/ready transfer and keeps a sliding window of the last DEPTH samples.
- Once the window is full, emits the running window sum and its truncated average on a registered valid/ready output.
- Feeds the monitoring/readout logic that follows ex1 in the exercise chain.

---
 rtl/ex1_pkg.sv | 13 +
 rtl/ex1_window_avg_if.sv | 26 ++
 rtl/ex1_win_buf.sv | 35 +++
 rtl/ex1_window_avg.sv | 120 ++++++++++++
 tb/tb_ex1_window_avg.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ex1_pkg.sv
// Shared defaults and state encoding for the ex1 window-average slice.
package ex1_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int LG_DEF    = 2;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ex1_window_avg_if.sv
// Sample-in / result-out handshake bundle for ex1_window_avg.
interface ex1_window_avg_if #(
  parameter int DW = 8,
  parameter int LG = 2
);

  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW+LG-1:0] o_sum;
  logic [DW-1:0]    o_avg;
  logic             o_valid;
  logic             o_ready;
  logic [LG:0]      o_cnt;

  modport master (
    output in_data, in_valid, o_ready,
    input  in_ready, o_sum, o_avg, o_valid, o_cnt
  );

  modport slave (
    input  in_data, in_valid, o_ready,
    output in_ready, o_sum, o_avg, o_valid, o_cnt
  );

endinterface

// File: rtl/ex1_win_buf.sv
// Circular sample store; presents the oldest entry (the one about to be
// overwritten) so the top can subtract it from the running sum.
module ex1_win_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int LG    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] oldest
);

  logic [DW-1:0] mem [DEPTH];
  logic [LG-1:0] wr_ptr;

  assign oldest = mem[wr_ptr];

  // Write one sample per accept; pointer wraps naturally since DEPTH = 2^LG.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + LG'(1);
    end
  end

endmodule

// File: rtl/ex1_window_avg.sv
// Sliding-window sum/average over the last DEPTH accepted samples, with a
// registered valid/ready result that sustains one sample per cycle.
module ex1_window_avg
  import ex1_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LG    = LG_DEF
) (
  input logic              clk,
  input logic              rst,
  input logic              clr,
  ex1_window_avg_if.slave  bus
);

  localparam int          SW   = DW + LG;
  localparam logic [LG:0] LAST = (LG+1)'(DEPTH - 1);

  state_t          state, state_nxt;
  logic            acc, otake, ld, cnt_inc, sub_old;
  logic [DW-1:0]   oldest;
  logic [SW-1:0]   sum, sum_nxt;
  logic [LG:0]     cnt;
  logic [SW-1:0]   sum_p1;
  logic [DW-1:0]   avg_p1;
  logic            vld_p1;

  function automatic logic [DW-1:0] avg_trunc(input logic [SW-1:0] s);
    avg_trunc = DW'(s >> LG);
  endfunction

  assign bus.in_ready = !vld_p1 || bus.o_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign otake        = vld_p1 && bus.o_ready;
  assign sum_nxt      = sum + SW'(bus.in_data) - (sub_old ? SW'(oldest) : SW'(0));

  ex1_win_buf #(.DW(DW), .DEPTH(DEPTH), .LG(LG)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .we     (acc),
    .wdata  (bus.in_data),
    .oldest (oldest)
  );

  // State register; clear returns to filling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= FILL;
    else if (clr) state <= FILL;
    else          state <= state_nxt;
  end

  // Next state: the accept that completes the window enters RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (acc && cnt == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = FILL;
    endcase
  end

  // Per-state controls: count while filling, subtract the oldest once full.
  always_comb begin
    cnt_inc = 1'b0;
    ld      = 1'b0;
    sub_old = 1'b0;
    case (state)
      FILL: begin
        cnt_inc = acc;
        ld      = acc && (cnt == LAST);
      end
      RUN: begin
        ld      = acc;
        sub_old = 1'b1;
      end
      default: ;
    endcase
  end

  // Running sum and fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
      cnt <= '0;
    end else if (clr) begin
      sum <= '0;
      cnt <= '0;
    end else begin
      if (acc)     sum <= sum_nxt;
      if (cnt_inc) cnt <= cnt + (LG+1)'(1);
    end
  end

  // ---- stage p1: registered result, held under backpressure ----
  // Load on every full-window accept; drop valid when taken with no reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_p1 <= '0;
      avg_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (clr) begin
      sum_p1 <= '0;
      avg_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (ld) begin
      sum_p1 <= sum_nxt;
      avg_p1 <= avg_trunc(sum_nxt);
      vld_p1 <= 1'b1;
    end else if (otake) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.o_sum   = sum_p1;
  assign bus.o_avg   = avg_p1;
  assign bus.o_valid = vld_p1;
  assign bus.o_cnt   = cnt;

endmodule

// File: tb/tb_ex1_window_avg.sv
// Bench for ex1_window_avg: table vectors, directed corner sequences and
// random traffic against a queue-based window model.
module tb_ex1_window_avg;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LG    = 2;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  ex1_window_avg_if #(.DW(DW), .LG(LG)) bus ();

  ex1_window_avg #(.DW(DW), .DEPTH(DEPTH), .LG(LG)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: the window is simply the list of the last DEPTH samples.
  int win[$];
  bit m_vld;
  int m_sum;

  typedef struct {
    int d;
    bit vld;
    int sum;
    int avg;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_vld = 1'b0;
    m_sum = 0;
  endtask

  function automatic int win_total();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic model_step(input bit acc, input bit otake, input bit c, input int d);
    if (c) begin
      model_reset();
    end else if (acc) begin
      win.push_back(d);
      if (win.size() > DEPTH) void'(win.pop_front());
      if (win.size() == DEPTH) begin
        m_sum = win_total();
        m_vld = 1'b1;
      end else if (otake) begin
        m_vld = 1'b0;
      end
    end else if (otake) begin
      m_vld = 1'b0;
    end
  endtask

  // One clock: drive at edge+1, check in_ready, clock, check outputs at edge+1.
  task automatic cycle(input bit v, input int d, input bit r, input bit c);
    bit acc, otake;
    bus.in_valid = v;
    bus.in_data  = DW'(d);
    bus.o_ready  = r;
    clr          = c;
    #1;
    chk("in_ready", int'(bus.in_ready), int'(!m_vld || r));
    acc   = v && (!m_vld || r);
    otake = m_vld && r;
    @(posedge clk);
    model_step(acc, otake, c, d);
    #1;
    chk("o_valid", int'(bus.o_valid), int'(m_vld));
    chk("o_sum",   int'(bus.o_sum),   m_sum);
    chk("o_avg",   int'(bus.o_avg),   m_sum / DEPTH);
    chk("o_cnt",   int'(bus.o_cnt),   (win.size() > DEPTH) ? DEPTH : win.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{11, 0,   0,  0};
    tbl[1] = '{22, 0,   0,  0};
    tbl[2] = '{33, 0,   0,  0};
    tbl[3] = '{44, 1, 110, 27};
    tbl[4] = '{55, 1, 154, 38};
    tbl[5] = '{66, 1, 198, 49};
    tbl[6] = '{77, 1, 242, 60};
    tbl[7] = '{88, 1, 286, 71};
    tbl[8] = '{99, 1, 330, 82};
    tbl[9] = '{11, 1, 275, 68};

    model_reset();
    rst          = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.o_ready  = 1'b1;
    #10;
    chk("rst_o_valid", int'(bus.o_valid), 0);
    chk("rst_o_sum",   int'(bus.o_sum),   0);
    chk("rst_o_avg",   int'(bus.o_avg),   0);
    chk("rst_o_cnt",   int'(bus.o_cnt),   0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Fill then slide, back to back with o_ready held high.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].d, 1'b1, 1'b0);
      chk("tbl_valid", int'(bus.o_valid), int'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("tbl_sum", int'(bus.o_sum), tbl[i].sum);
        chk("tbl_avg", int'(bus.o_avg), tbl[i].avg);
      end
    end

    // Backpressure after a fresh 110 result.
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 11, 1'b1, 1'b0);
    cycle(1'b1, 22, 1'b1, 1'b0);
    cycle(1'b1, 33, 1'b1, 1'b0);
    cycle(1'b1, 44, 1'b1, 1'b0);
    chk("bp_first", int'(bus.o_sum), 110);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 55, 1'b0, 1'b0);
      chk("bp_hold_sum", int'(bus.o_sum), 110);
      chk("bp_hold_vld", int'(bus.o_valid), 1);
    end
    cycle(1'b1, 55, 1'b1, 1'b0);
    chk("bp_release", int'(bus.o_sum), 154);

    // Full-scale samples, then one zero.
    for (int i = 0; i < 4; i++) cycle(1'b1, 255, 1'b1, 1'b0);
    chk("max_sum", int'(bus.o_sum), 1020);
    chk("max_avg", int'(bus.o_avg), 255);
    cycle(1'b1, 0, 1'b1, 1'b0);
    chk("drop_sum", int'(bus.o_sum), 765);
    chk("drop_avg", int'(bus.o_avg), 191);

    // Clear mid-fill discards the earlier samples; accept in clr cycle ignored.
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 11, 1'b1, 1'b0);
    cycle(1'b1, 22, 1'b1, 1'b0);
    cycle(1'b1, 200, 1'b1, 1'b1);
    chk("clr_cnt", int'(bus.o_cnt), 0);
    cycle(1'b1, 33, 1'b1, 1'b0);
    cycle(1'b1, 44, 1'b1, 1'b0);
    cycle(1'b1, 55, 1'b1, 1'b0);
    chk("clr_novld", int'(bus.o_valid), 0);
    cycle(1'b1, 66, 1'b1, 1'b0);
    chk("clr_sum", int'(bus.o_sum), 198);
    chk("clr_avg", int'(bus.o_avg), 49);

    // Asynchronous reset between edges while a result is valid.
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", int'(bus.o_valid), 0);
    chk("arst_sum", int'(bus.o_sum), 0);
    chk("arst_avg", int'(bus.o_avg), 0);
    chk("arst_cnt", int'(bus.o_cnt), 0);
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 2, 1'b1, 1'b0);
    cycle(1'b1, 3, 1'b1, 1'b0);
    chk("arst_refill_novld", int'(bus.o_valid), 0);
    cycle(1'b1, 4, 1'b1, 1'b0);
    chk("arst_refill_sum", int'(bus.o_sum), 10);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, int'($urandom_range(0, 255)),
            ($urandom % 3) != 0, ($urandom % 50) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
